// File: rtl/serial_seq_detector_pkg.sv
// serial_seq_detector_pkg: shared types and default constants for the serial sequence detector
package seq_det_pkg;
    typedef enum logic {FILL, ARMED} state_t;
    localparam int DEF_PATTERN_W = 4;
    localparam logic [DEF_PATTERN_W-1:0] DEF_PATTERN = 4'b1011;
    localparam int DEF_CNT_W = 8;
    localparam logic [DEF_CNT_W-1:0] DEF_CNT_MAX = '1;
endpackage

// File: rtl/serial_seq_detector_if.sv
// serial_seq_detector_if: serial input qualifiers and detector outputs
interface serial_seq_detector_if #(
    parameter int PATTERN_W = 4,
    parameter int CNT_W = 8
);
    logic en;
    logic d;
    logic clr;
    logic match;
    logic [CNT_W-1:0] match_count;
    logic [PATTERN_W-1:0] history;
    modport master(output en, d, clr, input match, match_count, history);
    modport slave(input en, d, clr, output match, match_count, history);
endinterface

// File: rtl/serial_seq_detector_sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    // clear wins over increment; increment stops at the maximum value
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && cnt != '1) cnt <= cnt + W'(1);
endmodule

// File: rtl/serial_seq_detector.sv
// serial_seq_detector: detects a serial bit pattern, pulses match and counts hits
module serial_seq_detector
    import seq_det_pkg::*;
#(
    parameter int PATTERN_W = DEF_PATTERN_W,
    parameter logic [PATTERN_W-1:0] PATTERN = DEF_PATTERN,
    parameter bit OVERLAP = 1'b1,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic clk,
    input logic reset,
    serial_seq_detector_if.slave bus
);
    localparam int FW = $clog2(PATTERN_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PATTERN_W);
    state_t state, state_nx;
    logic [PATTERN_W-1:0] hist, hist_nx;
    logic [FW-1:0] fill, fill_nx;
    logic hit, match_r;
    logic [CNT_W-1:0] cnt;
    // next history/fill for an accepted bit; a hit needs a full window equal to the pattern
    always_comb begin
        hist_nx = {hist[PATTERN_W-2:0], bus.d};
        fill_nx = (state == ARMED) ? FULL : fill + FW'(1);
        hit = bus.en && hist_nx == PATTERN && fill_nx == FULL;
        state_nx = state;
        if (bus.en) state_nx = (fill_nx == FULL && !(hit && !OVERLAP)) ? ARMED : FILL;
        if (hit && !OVERLAP) fill_nx = '0;
    end
    // state, history and fill update only on accepted bits; clr discards the bit
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= FILL;
            hist <= '0;
            fill <= '0;
            match_r <= 1'b0;
        end else if (bus.clr) begin
            state <= FILL;
            hist <= '0;
            fill <= '0;
            match_r <= 1'b0;
        end else begin
            match_r <= hit;
            if (bus.en) begin
                state <= state_nx;
                hist <= hist_nx;
                fill <= fill_nx;
            end
        end
    sat_counter #(.W(CNT_W)) u_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (hit),
        .clr  (bus.clr),
        .cnt  (cnt)
    );
    assign bus.match = match_r;
    assign bus.match_count = cnt;
    assign bus.history = hist;
endmodule

// File: tb/tb_serial_seq_detector.sv
// tb_serial_seq_detector: directed vectors with a queued scoreboard over three detector configurations
module tb_serial_seq_detector;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en_s = 1'b0;
    logic d_s = 1'b0;
    logic clr_s = 1'b0;
    int sel = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        int inst;
        int tag;
        logic m;
        logic [7:0] c;
        logic [3:0] h;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    serial_seq_detector_if #(.PATTERN_W(4), .CNT_W(8)) i_a ();
    serial_seq_detector_if #(.PATTERN_W(4), .CNT_W(8)) i_b ();
    serial_seq_detector_if #(.PATTERN_W(4), .CNT_W(2)) i_c ();

    assign i_a.en = en_s && sel == 0;
    assign i_b.en = en_s && sel == 1;
    assign i_c.en = en_s && sel == 2;
    assign i_a.clr = clr_s && sel == 0;
    assign i_b.clr = clr_s && sel == 1;
    assign i_c.clr = clr_s && sel == 2;
    assign i_a.d = d_s;
    assign i_b.d = d_s;
    assign i_c.d = d_s;

    serial_seq_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
        .clk(clk), .reset(reset), .bus(i_a.slave));
    serial_seq_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_no (
        .clk(clk), .reset(reset), .bus(i_b.slave));
    serial_seq_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_c2 (
        .clk(clk), .reset(reset), .bus(i_c.slave));

    logic mm[3];
    logic [7:0] cc[3];
    logic [3:0] hh[3];
    assign mm[0] = i_a.match;
    assign mm[1] = i_b.match;
    assign mm[2] = i_c.match;
    assign cc[0] = i_a.match_count;
    assign cc[1] = i_b.match_count;
    assign cc[2] = {6'b0, i_c.match_count};
    assign hh[0] = i_a.history;
    assign hh[1] = i_b.history;
    assign hh[2] = i_c.history;

    task automatic cmp(input string name, input int tag, input int inst, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s vec%0d inst%0d: got %0h want %0h", name, tag, inst, act, want);
        end
    endtask

    // one clock of stimulus; the expected outputs after this edge go to the scoreboard
    task automatic step(input logic e, input logic dd, input logic c, input logic em, input int ec,
                        input logic [3:0] eh, input int tag);
        exp_t x;
        @(negedge clk);
        en_s = e;
        d_s = dd;
        clr_s = c;
        @(posedge clk);
        x.inst = sel;
        x.tag = tag;
        x.m = em;
        x.c = 8'(ec);
        x.h = eh;
        q.push_back(x);
        #1;
        en_s = 1'b0;
        clr_s = 1'b0;
    endtask

    // monitor: compares the DUT outputs against the oldest expectation on each falling edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp("match", e.tag, e.inst, 32'(mm[e.inst]), 32'(e.m));
            cmp("count", e.tag, e.inst, 32'(cc[e.inst]), 32'(e.c));
            cmp("history", e.tag, e.inst, 32'(hh[e.inst]), 32'(e.h));
        end
    end

    initial begin
        logic [3:0] h;
        logic [3:0] pat;
        // reset held with random traffic
        repeat (2) begin
            @(negedge clk);
            en_s = 1'($urandom_range(0, 1));
            d_s = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        en_s = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sel = i;
            step(0, 0, 0, 0, 0, 4'b0000, 1);
        end
        // reset mid-stream after three pattern bits
        sel = 0;
        step(1, 1, 0, 0, 0, 4'b0001, 2);
        step(1, 0, 0, 0, 0, 4'b0010, 2);
        step(1, 1, 0, 0, 0, 4'b0101, 2);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        cmp("rst_match", 3, 0, 32'(mm[0]), 0);
        cmp("rst_count", 3, 0, 32'(cc[0]), 0);
        cmp("rst_history", 3, 0, 32'(hh[0]), 0);
        step(1, 1, 0, 0, 0, 4'b0000, 4);
        @(negedge clk);
        reset = 1'b1;
        step(1, 1, 0, 0, 0, 4'b0001, 5);
        step(1, 0, 0, 0, 0, 4'b0010, 5);
        // overlapping stream 1,0,1,1,0,1,1
        step(0, 0, 1, 0, 0, 4'b0000, 6);
        step(1, 1, 0, 0, 0, 4'b0001, 7);
        step(1, 0, 0, 0, 0, 4'b0010, 7);
        step(1, 1, 0, 0, 0, 4'b0101, 7);
        step(1, 1, 0, 1, 1, 4'b1011, 7);
        step(1, 0, 0, 0, 1, 4'b0110, 7);
        step(1, 1, 0, 0, 1, 4'b1101, 7);
        step(1, 1, 0, 1, 2, 4'b1011, 7);
        step(0, 0, 0, 0, 2, 4'b1011, 7);
        // non-overlapping: same stream, then 1,0,1,1
        sel = 1;
        step(1, 1, 0, 0, 0, 4'b0001, 8);
        step(1, 0, 0, 0, 0, 4'b0010, 8);
        step(1, 1, 0, 0, 0, 4'b0101, 8);
        step(1, 1, 0, 1, 1, 4'b1011, 8);
        step(1, 0, 0, 0, 1, 4'b0110, 8);
        step(1, 1, 0, 0, 1, 4'b1101, 8);
        step(1, 1, 0, 0, 1, 4'b1011, 8);
        step(1, 1, 0, 0, 1, 4'b0111, 9);
        step(1, 0, 0, 0, 1, 4'b1110, 9);
        step(1, 1, 0, 0, 1, 4'b1101, 9);
        step(1, 1, 0, 1, 2, 4'b1011, 9);
        step(0, 1, 0, 0, 2, 4'b1011, 9);
        // en gating with hold cycles between accepted bits
        sel = 0;
        step(0, 0, 1, 0, 0, 4'b0000, 10);
        step(1, 1, 0, 0, 0, 4'b0001, 11);
        step(0, 0, 0, 0, 0, 4'b0001, 11);
        step(1, 0, 0, 0, 0, 4'b0010, 11);
        step(0, 1, 0, 0, 0, 4'b0010, 11);
        step(1, 1, 0, 0, 0, 4'b0101, 11);
        step(0, 0, 0, 0, 0, 4'b0101, 11);
        step(1, 1, 0, 1, 1, 4'b1011, 11);
        step(0, 1, 0, 0, 1, 4'b1011, 11);
        // clr coincident with the final pattern bit
        step(0, 0, 1, 0, 0, 4'b0000, 12);
        step(1, 1, 0, 0, 0, 4'b0001, 13);
        step(1, 0, 0, 0, 0, 4'b0010, 13);
        step(1, 1, 0, 0, 0, 4'b0101, 13);
        step(1, 1, 1, 0, 0, 4'b0000, 13);
        step(1, 1, 0, 0, 0, 4'b0001, 14);
        step(1, 0, 0, 0, 0, 4'b0010, 14);
        step(1, 1, 0, 0, 0, 4'b0101, 14);
        step(1, 1, 0, 1, 1, 4'b1011, 14);
        // 2-bit counter saturates at 3 across six occurrences
        sel = 2;
        pat = 4'b1011;
        h = 4'b0000;
        for (int k = 0; k < 24; k++) begin
            logic b;
            b = pat[3 - (k % 4)];
            h = {h[2:0], b};
            step(1, b, 0, (k % 4) == 3, ((k + 1) / 4 > 3) ? 3 : (k + 1) / 4, h, 15);
        end
        step(0, 0, 0, 0, 3, 4'b1011, 15);
        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
